// File: rtl/sparse_mac_pe.sv
// Sparse dot-product processing element: pops (data, index) pairs from a FIFO,
// multiplies each by a locally stored weight and accumulates the products.
module sparse_mac_pe #(
    parameter int unsigned D_WIDTH   = 16,
    parameter int unsigned I_WIDTH   = 4,
    parameter int unsigned ACC_WIDTH = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           len,
    input  logic                 w_wr_en,
    input  logic [I_WIDTH-1:0]   w_wr_addr,
    input  logic [D_WIDTH-1:0]   w_wr_data,
    input  logic                 fifo_empty,
    output logic                 fifo_r_en,
    input  logic [D_WIDTH-1:0]   fifo_data,
    input  logic [I_WIDTH-1:0]   fifo_index,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 acc_valid,
    output logic                 busy
);

    localparam int unsigned NumW    = 2 ** I_WIDTH;
    localparam int unsigned P_WIDTH = 2 * D_WIDTH;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                     state_q, state_d;
    logic [7:0]                 issue_cnt_q, issue_cnt_d;
    logic                       rd_v_q, rd_v_d;
    logic                       prod_v_q, prod_v_d;
    logic signed [P_WIDTH-1:0]  prod_q, prod_d;
    logic [ACC_WIDTH-1:0]       acc_q, acc_d;
    logic [D_WIDTH-1:0]         weights_q [NumW];
    logic [D_WIDTH-1:0]         weights_d [NumW];
    logic signed [P_WIDTH-1:0]  mul_a, mul_b;

    // Reset gates the strobe directly so no entry is popped during the reset cycle.
    always_comb begin
        fifo_r_en = (state_q == StRun) && !fifo_empty && (issue_cnt_q != 8'd0) && !rst;
        busy      = (state_q != StIdle);
        acc_valid = (state_q == StDone);
        acc_out   = acc_q;
    end

    always_comb begin
        mul_a = P_WIDTH'($signed(fifo_data));
        mul_b = P_WIDTH'($signed(weights_q[fifo_index]));
    end

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        rd_v_d      = fifo_r_en;
        prod_v_d    = rd_v_q;
        prod_d      = prod_q;
        acc_d       = acc_q;
        weights_d   = weights_q;

        if (w_wr_en) begin
            weights_d[w_wr_addr] = w_wr_data;
        end
        // Lookup reads the registered table, so a same-cycle write is not yet visible.
        if (rd_v_q) begin
            prod_d = mul_a * mul_b;
        end
        if (prod_v_q) begin
            acc_d = acc_q + ACC_WIDTH'(prod_q);
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d = '0;
                    if (len != 8'd0) begin
                        issue_cnt_d = len;
                        state_d     = StRun;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                if (fifo_r_en) begin
                    issue_cnt_d = issue_cnt_q - 8'd1;
                    if (issue_cnt_q == 8'd1) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (!rd_v_q && !prod_v_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            issue_cnt_q <= '0;
            rd_v_q      <= 1'b0;
            prod_v_q    <= 1'b0;
            prod_q      <= '0;
            acc_q       <= '0;
            weights_q   <= '{default: '0};
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            rd_v_q      <= rd_v_d;
            prod_v_q    <= prod_v_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            weights_q   <= weights_d;
        end
    end

endmodule

// File: tb/tb_sparse_mac_pe.sv
// Self-checking bench for sparse_mac_pe: a queue-based FIFO model feeds the DUT and
// expected sums are computed arithmetically from the entries and a shadow weight table.
module tb_sparse_mac_pe;

    localparam int DW = 16;
    localparam int IW = 4;
    localparam int AW = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    len = '0;
    logic          w_wr_en = 1'b0;
    logic [IW-1:0] w_wr_addr = '0;
    logic [DW-1:0] w_wr_data = '0;
    logic          fifo_empty;
    logic          fifo_r_en;
    logic [DW-1:0] fifo_data = '0;
    logic [IW-1:0] fifo_index = '0;
    logic [AW-1:0] acc_out;
    logic          acc_valid;
    logic          busy;

    always #5 clk = ~clk;

    sparse_mac_pe #(.D_WIDTH(DW), .I_WIDTH(IW), .ACC_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .w_wr_en    (w_wr_en),
        .w_wr_addr  (w_wr_addr),
        .w_wr_data  (w_wr_data),
        .fifo_empty (fifo_empty),
        .fifo_r_en  (fifo_r_en),
        .fifo_data  (fifo_data),
        .fifo_index (fifo_index),
        .acc_out    (acc_out),
        .acc_valid  (acc_valid),
        .busy       (busy)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [IW-1:0] i;
    } ent_t;

    ent_t fq[$];
    ent_t pend[$];
    ent_t pe;
    int   push_cnt = 0;
    int   pop_cnt = 0;
    int   underflow = 0;

    assign fifo_empty = (push_cnt == pop_cnt);

    // FIFO with registered outputs: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (fifo_r_en) begin
            if (fq.size() == 0) begin
                underflow <= underflow + 1;
            end else begin
                pe = fq.pop_front();
                fifo_data  <= pe.d;
                fifo_index <= pe.i;
                pop_cnt    <= pop_cnt + 1;
            end
        end
    end

    logic signed [DW-1:0] wm [1 << IW];
    longint               exp_sum;
    int                   checks = 0;
    int                   errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_w(input logic [IW-1:0] a, input logic [DW-1:0] v);
        @(negedge clk);
        w_wr_en   = 1'b1;
        w_wr_addr = a;
        w_wr_data = v;
        @(negedge clk);
        w_wr_en = 1'b0;
        wm[a] = $signed(v);
    endtask

    task automatic push_ent(input logic [DW-1:0] d, input logic [IW-1:0] i, input bit later);
        ent_t e;
        e.d = d;
        e.i = i;
        exp_sum += longint'($signed(d)) * longint'(wm[i]);
        if (later) begin
            pend.push_back(e);
        end else begin
            fq.push_back(e);
            push_cnt++;
        end
    endtask

    task automatic release_pend();
        while (pend.size() > 0) begin
            fq.push_back(pend.pop_front());
            push_cnt++;
        end
    endtask

    // Cycle c is the c-th clock period after the edge that samples start.
    task automatic run_dot(input int l, input int push_at, input int restart_at,
                           input int wr_at, input logic [IW-1:0] wa, input logic [DW-1:0] wd,
                           output int vcyc, output int nren, output int fren, output int lren,
                           output logic [AW-1:0] accv, output int bad);
        vcyc = -1; nren = 0; fren = -1; lren = -1; bad = 0; accv = '0;
        @(negedge clk);
        start = 1'b1;
        len   = l[7:0];
        @(posedge clk);
        for (int c = 1; c <= l + 60; c++) begin
            @(negedge clk);
            start   = 1'b0;
            w_wr_en = 1'b0;
            if (fifo_r_en) begin
                nren++;
                if (fren < 0) fren = c;
                lren = c;
                if (fifo_empty) bad++;
            end
            if (acc_valid) begin
                vcyc = c;
                accv = acc_out;
                break;
            end
            if (c == restart_at) begin
                start = 1'b1;
                len   = 8'd9;
            end
            if (c == wr_at) begin
                w_wr_en   = 1'b1;
                w_wr_addr = wa;
                w_wr_data = wd;
            end
            if (c == push_at) release_pend();
        end
        start   = 1'b0;
        w_wr_en = 1'b0;
    endtask

    task automatic post_chk(input string tag, input logic [AW-1:0] ev);
        @(negedge clk);
        check({tag, "_valid_drop"}, 64'(acc_valid), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        check({tag, "_hold"}, 64'(acc_out), 64'(ev));
    endtask

    initial begin
        int            vc, nr, fr, lr, bad, p0, l, nlater, pat;
        logic [AW-1:0] av, ev;
        logic [DW-1:0] rd;
        for (int k = 0; k < (1 << IW); k++) wm[k] = '0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(acc_valid), 64'd0);
        check("rst_ren", 64'(fifo_r_en), 64'd0);
        check("rst_acc", 64'(acc_out), 64'd0);

        // Basic three-entry dot product.
        write_w(4'd0, 16'd3);
        write_w(4'd1, 16'hFFFE);
        write_w(4'd5, 16'd7);
        exp_sum = 0;
        push_ent(16'd10, 4'd0, 1'b0);
        push_ent(16'd4, 4'd1, 1'b0);
        push_ent(16'hFFFF, 4'd5, 1'b0);
        run_dot(3, -1, -1, -1, '0, '0, vc, nr, fr, lr, av, bad);
        check("s1_first_ren", 64'(fr), 64'd1);
        check("s1_last_ren", 64'(lr), 64'd3);
        check("s1_num_ren", 64'(nr), 64'd3);
        check("s1_valid_cyc", 64'(vc), 64'd7);
        check("s1_acc", 64'(av), 64'd15);
        post_chk("s1", 40'd15);

        // Zero length: straight to DONE, accumulator cleared.
        run_dot(0, -1, -1, -1, '0, '0, vc, nr, fr, lr, av, bad);
        check("len0_valid_cyc", 64'(vc), 64'd1);
        check("len0_num_ren", 64'(nr), 64'd0);
        check("len0_acc", 64'(av), 64'd0);
        post_chk("len0", 40'd0);

        // FIFO runs dry after one entry; the rest arrive in cycle 5.
        exp_sum = 0;
        push_ent(16'd2, 4'd5, 1'b0);
        push_ent(16'd3, 4'd0, 1'b1);
        push_ent(16'hFFFA, 4'd1, 1'b1);
        ev = exp_sum[AW-1:0];
        p0 = pop_cnt;
        run_dot(3, 5, -1, -1, '0, '0, vc, nr, fr, lr, av, bad);
        check("stall_bad_ren", 64'(bad), 64'd0);
        check("stall_pops", 64'(pop_cnt - p0), 64'd3);
        check("stall_valid_cyc", 64'(vc), 64'd10);
        check("stall_acc", 64'(av), 64'(ev));
        check("stall_acc_const", 64'(av), 64'd35);

        // Weight write colliding with a lookup of the same address.
        write_w(4'd2, 16'd4);
        exp_sum = 0;
        push_ent(16'd5, 4'd2, 1'b0);
        run_dot(1, -1, -1, 2, 4'd2, 16'd100, vc, nr, fr, lr, av, bad);
        wm[2] = 16'sd100;
        check("coll_old_w", 64'(av), 64'd20);
        exp_sum = 0;
        push_ent(16'd5, 4'd2, 1'b0);
        run_dot(1, -1, -1, -1, '0, '0, vc, nr, fr, lr, av, bad);
        check("coll_new_w", 64'(av), 64'd500);

        // Start pulsed again while busy must be ignored.
        exp_sum = 0;
        for (int k = 0; k < 4; k++) begin
            rd = DW'($urandom);
            push_ent(rd, IW'($urandom_range(0, 15)), 1'b0);
        end
        ev = exp_sum[AW-1:0];
        run_dot(4, -1, 2, -1, '0, '0, vc, nr, fr, lr, av, bad);
        check("restart_num_ren", 64'(nr), 64'd4);
        check("restart_valid_cyc", 64'(vc), 64'd8);
        check("restart_acc", 64'(av), 64'(ev));

        // Largest-magnitude products: 64 * (-32768)^2 = 2^36.
        write_w(4'd3, 16'h8000);
        exp_sum = 0;
        for (int k = 0; k < 64; k++) push_ent(16'h8000, 4'd3, 1'b0);
        ev = exp_sum[AW-1:0];
        run_dot(64, -1, -1, -1, '0, '0, vc, nr, fr, lr, av, bad);
        check("big_valid_cyc", 64'(vc), 64'd68);
        check("big_acc", 64'(av), 64'h10_0000_0000);
        check("big_acc_model", 64'(av), 64'(ev));

        // Randomized runs, some with a delayed second batch of entries.
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < 3; k++) begin
                rd = DW'($urandom);
                write_w(IW'($urandom_range(0, 15)), rd);
            end
            l      = $urandom_range(1, 24);
            nlater = ((it % 2) == 1 && l > 1) ? $urandom_range(1, l - 1) : 0;
            pat    = (nlater > 0) ? $urandom_range(2, 8) : -1;
            exp_sum = 0;
            for (int k = 0; k < l; k++) begin
                rd = DW'($urandom);
                push_ent(rd, IW'($urandom_range(0, 15)), k >= (l - nlater));
            end
            ev = exp_sum[AW-1:0];
            p0 = pop_cnt;
            run_dot(l, pat, -1, -1, '0, '0, vc, nr, fr, lr, av, bad);
            check($sformatf("rnd%0d_acc", it), 64'(av), 64'(ev));
            check($sformatf("rnd%0d_pops", it), 64'(pop_cnt - p0), 64'(l));
            check($sformatf("rnd%0d_bad_ren", it), 64'(bad), 64'd0);
            if (nlater == 0) check($sformatf("rnd%0d_valid_cyc", it), 64'(vc), 64'(l + 4));
        end

        // Reset in RUN after two of five pops.
        for (int k = 0; k < 5; k++) push_ent(16'd7, 4'd0, 1'b0);
        p0 = pop_cnt;
        @(negedge clk);
        start = 1'b1;
        len   = 8'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20 && (pop_cnt - p0) < 2; c++) @(negedge clk);
        check("mid_pops_before_rst", 64'(pop_cnt - p0), 64'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_ren_gated", 64'(fifo_r_en), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_acc", 64'(acc_out), 64'd0);
        check("mid_rst_ren", 64'(fifo_r_en), 64'd0);
        fq.delete();
        push_cnt = pop_cnt;
        for (int k = 0; k < (1 << IW); k++) wm[k] = '0;
        exp_sum = 0;
        push_ent(16'd7, 4'd0, 1'b0);
        push_ent(16'd7, 4'd1, 1'b0);
        push_ent(16'd7, 4'd5, 1'b0);
        push_ent(16'd7, 4'd3, 1'b0);
        push_ent(16'd7, 4'd2, 1'b0);
        run_dot(5, -1, -1, -1, '0, '0, vc, nr, fr, lr, av, bad);
        check("mid_rst_weights_zero", 64'(av), 64'd0);
        check("mid_rst_valid_cyc", 64'(vc), 64'd9);

        check("fifo_drained", 64'(fq.size()), 64'd0);
        check("no_underflow", 64'(underflow), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
